// File: rtl/vector_sequencer_pkg.sv
// Shared types and constants for the vector_sequencer self-check harness.
// EXPECTED_Y is the truth table of the gate block under test, indexed by {a,b,c}.
package vector_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [7:0] EXPECTED_Y = 8'b0011_0001;
   localparam logic [2:0] VEC_LAST   = 3'd7;

   function automatic logic expected_y(input logic [2:0] vec);
      return EXPECTED_Y[vec];
   endfunction

endpackage

// File: rtl/vector_sequencer_sync2.sv
// Generic two-flop synchronizer with synchronous active-high reset.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/vector_sequencer.sv
// Drives all eight {a,b,c} vectors into a gate block, samples y after a settle
// interval and checks it. VECTOR_SEQUENCER_SYNC_Y_EN adds a 2-flop sync on y.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// APPLY  | vector on a,b,c, settle counter loaded
// SETTLE | down-counting until terminal count 0
// SAMPLE | y compared against the truth table, vec advanced
// DONE   | one-cycle done pulse
module vector_sequencer
   import vector_sequencer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 8,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             y,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             busy,
   output logic             done,
   output logic [ERR_W-1:0] err_count,
   output logic             fail,
   output logic [2:0]       mismatch_vec,
   output logic             mismatch_valid
);

   localparam int               CNT_W   = 9;
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   state_t           state, state_nxt;
   logic [2:0]       vec;
   logic [CNT_W-1:0] settle_cnt;
   logic             y_cmp;
   logic             mismatch;

`ifdef VECTOR_SEQUENCER_SYNC_Y_EN
   // two extra settle cycles absorb the synchronizer latency
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES + 1);

   sync2 #(.W(1)) u_sync_y (
      .clk   (clk),
      .reset (reset),
      .d     (y),
      .q     (y_cmp)
   );
`else
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   assign y_cmp = y;
`endif

   assign {a, b, c} = vec;
   assign mismatch  = (y_cmp != expected_y(vec));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = APPLY;
         APPLY:   state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == '0) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = (vec == VEC_LAST) ? DONE : APPLY;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vec            <= '0;
         settle_cnt     <= '0;
         err_count      <= '0;
         fail           <= 1'b0;
         mismatch_vec   <= '0;
         mismatch_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  vec            <= '0;
                  settle_cnt     <= '0;
                  err_count      <= '0;
                  fail           <= 1'b0;
                  mismatch_vec   <= '0;
                  mismatch_valid <= 1'b0;
               end
            end
            APPLY:  settle_cnt <= SETTLE_LOAD;
            SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
            SAMPLE: begin
               if (mismatch) begin
                  if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                  fail <= 1'b1;
                  if (!mismatch_valid) begin
                     mismatch_vec   <= vec;
                     mismatch_valid <= 1'b1;
                  end
               end
               if (vec != VEC_LAST) vec <= vec + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: gate-block model with settling delay,
// stuck-at faults, counter saturation, mid-run reset and held start.
module tb_vector_sequencer;

   localparam int S = 8;
`ifdef VECTOR_SEQUENCER_SYNC_Y_EN
   localparam int PER_VEC = S + 4;
`else
   localparam int PER_VEC = S + 2;
`endif
   localparam int RUN_LAT = 1 + 8 * PER_VEC;
   localparam int BUDGET  = RUN_LAT + 50;

   logic       clk, reset, start, y;
   logic       a, b, c, busy, done, fail, mvalid;
   logic [3:0] err;
   logic [2:0] mvec;

   logic       start2, y2;
   logic       a2, b2, c2, busy2, done2, fail2, mvalid2;
   logic [1:0] err2;
   logic [2:0] mvec2;

   int         n_tests, n_fail;
   int         mode;
   int         age;
   int         lat;
   logic [2:0] last_abc;

   vector_sequencer #(.SETTLE_CYCLES(S), .ERR_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .y(y),
      .a(a), .b(b), .c(c), .busy(busy), .done(done),
      .err_count(err), .fail(fail), .mismatch_vec(mvec), .mismatch_valid(mvalid)
   );

   vector_sequencer #(.SETTLE_CYCLES(S), .ERR_W(2)) dut_e2 (
      .clk(clk), .reset(reset), .start(start2), .y(y2),
      .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2),
      .err_count(err2), .fail(fail2), .mismatch_vec(mvec2), .mismatch_valid(mvalid2)
   );

   always #5 clk = ~clk;

   // y = 1 for 000, 100, 101
   function automatic logic ref_y(input logic [2:0] v);
      return (~v[2] & ~v[1] & ~v[0]) | (v[2] & ~v[1]);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: block output is wrong until S cycles after a vector change
   task automatic tick();
      @(posedge clk);
      #1;
      if ({a, b, c} != last_abc) begin
         last_abc = {a, b, c};
         age      = 0;
      end else if (age < 100000) begin
         age++;
      end
      case (mode)
         0:       y = (age >= S) ? ref_y(last_abc) : ~ref_y(last_abc);
         1:       y = 1'b0;
         default: y = 1'b1;
      endcase
   endtask

   task automatic do_run(input bit hold, output int l);
      logic [2:0] prev;
      start = 1'b1;
      tick();
      l = 1;
      if (!hold) start = 1'b0;
      check("first_vec", {a, b, c}, 3'b000);
      check("busy_at_apply", busy, 1'b1);
      prev = {a, b, c};
      while (!done && l < BUDGET) begin
         tick();
         l++;
         if ({a, b, c} != prev) begin
            check("vec_order", {a, b, c}, 3'(prev + 3'd1));
            prev = {a, b, c};
         end
      end
      if (!done) check("done_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      clk      = 1'b0;
      reset    = 1'b1;
      start    = 1'b0;
      start2   = 1'b0;
      y        = 1'b0;
      y2       = 1'b0;
      mode     = 0;
      age      = 1000;
      last_abc = 3'b000;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      check("reset_state", {a, b, c, busy, done, err, fail, mvec, mvalid}, 14'd0);

      // correct block
      mode = 0;
      do_run(1'b0, lat);
      check("latency_ok", lat, RUN_LAT);
      check("busy_in_done", busy, 1'b1);
      check("ok_result", {err, fail, mvalid}, 6'd0);
      tick();
      check("done_pulse_end", {done, busy}, 2'b00);
      check("end_vec", {a, b, c}, 3'b111);

      // stuck at 0
      mode = 1;
      do_run(1'b0, lat);
      check("s0_err", err, 4'd3);
      check("s0_fail", fail, 1'b1);
      check("s0_mvec", {mvalid, mvec}, 4'b1_000);
      repeat (3) tick();
      check("s0_hold", {err, fail, mvalid, mvec}, {4'd3, 1'b1, 1'b1, 3'b000});

      // stuck at 1, wide counter
      mode = 2;
      do_run(1'b0, lat);
      check("s1_err", err, 4'd5);
      check("s1_mvec", {mvalid, mvec}, 4'b1_001);

      // stuck at 1, ERR_W=2 saturates
      y2     = 1'b1;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      lat    = 1;
      while (!done2 && lat < BUDGET) begin
         tick();
         lat++;
      end
      check("e2_latency", lat, RUN_LAT);
      check("e2_err_sat", err2, 2'd3);
      check("e2_fail", fail2, 1'b1);
      check("e2_mvec", {mvalid2, mvec2}, 4'b1_001);

      // reset in the middle of vector 3
      mode  = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat   = 0;
      while ({a, b, c} != 3'd3 && lat < BUDGET) begin
         tick();
         lat++;
      end
      check("reach_vec3", {a, b, c}, 3'd3);
      tick();
      tick();
      check("pre_reset_err", {err, fail}, {4'd1, 1'b1});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrun_reset", {a, b, c, busy, done, err, fail, mvec, mvalid}, 14'd0);
      mode = 0;
      do_run(1'b0, lat);
      check("post_reset_latency", lat, RUN_LAT);
      check("post_reset_result", {err, fail, mvalid}, 6'd0);
      tick();

      // start held through a run
      mode = 1;
      do_run(1'b1, lat);
      check("held_latency", lat, RUN_LAT);
      check("held_err", err, 4'd3);
      tick();
      check("held_idle", {busy, done, err}, {1'b0, 1'b0, 4'd3});
      tick();
      check("held_restart", {busy, a, b, c, err, fail, mvalid}, {1'b1, 3'b000, 4'd0, 1'b0, 1'b0});
      start = 1'b0;
      lat   = 0;
      while (!done && lat < BUDGET) begin
         tick();
         lat++;
      end
      check("second_run_err", err, 4'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
